swap_seq_ctrl: RTL and testbench

//   Sequencer for a W-stage load/rotate register ring, such as the two-flip-flop swap register.
//   The ring is driven through its load/d inputs.
//   On a start request the block shifts a parallel word into the ring serially with load=1.
//   It then releases load so the ring rotates for a programmed number of clock cycles.
//   It signals completion with a one-cycle done pulse.
//   It sits between a test/control FSM and the ring, which shares ck with it.
//

---
 rtl/swap_seq_ctrl_if.sv | 25 ++
 rtl/swap_seq_ctrl.sv | 111 +++++++++++
 tb/tb_swap_seq_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/swap_seq_ctrl_if.sv
// Handshake bundle between the control FSM, the sequencer and the load/rotate ring.
// The master side is the requester; the slave side is the sequencer itself.
interface swap_seq_ctrl_if #(
  parameter int W  = 2,
  parameter int CW = 8
);
  logic          start;
  logic [W-1:0]  din;
  logic [CW-1:0] ncyc;
  logic          stop;
  logic          load;
  logic          d;
  logic          busy;
  logic          done;

  modport master (
    output start, din, ncyc, stop,
    input  load, d, busy, done
  );

  modport slave (
    input  start, din, ncyc, stop,
    output load, d, busy, done
  );
endinterface

// File: rtl/swap_seq_ctrl.sv
// Sequencer for a W-stage load/rotate ring: shifts a word in MSB first,
// rotates for a programmed number of cycles, then pulses done for one cycle.
module swap_seq_ctrl #(
  parameter int W  = 2,
  parameter int CW = 8
) (
  input  logic           ck,
  input  logic           cl,
  swap_seq_ctrl_if.slave bus
);
  localparam int BW = (W > 1) ? $clog2(W) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [BW-1:0] LAST_BIT = BW'(W - 1);

  logic [1:0]    state;
  logic [W-1:0]  shreg;
  logic [W-1:0]  shifted;
  logic [CW-1:0] cnt;
  logic [BW-1:0] bitcnt;
  logic          load_q;
  logic          d_q;
  logic          busy_q;
  logic          done_q;

  // The next serial bit always sits at the top of the shift register.
  assign shifted = shreg << 1;

  assign bus.load = load_q;
  assign bus.d    = d_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

  // Outputs default low each cycle; each state only raises what it needs,
  // so every exit to IDLE (stop, DONE) leaves the ring interface quiet.
  always_ff @(posedge ck) begin
    if (cl) begin
      state  <= IDLE;
      shreg  <= '0;
      cnt    <= '0;
      bitcnt <= '0;
      load_q <= 1'b0;
      d_q    <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      load_q <= 1'b0;
      d_q    <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state  <= LOAD;
            shreg  <= bus.din;
            cnt    <= bus.ncyc;
            bitcnt <= '0;
            load_q <= 1'b1;
            busy_q <= 1'b1;
            d_q    <= bus.din[W-1];
          end
        end
        LOAD: begin
          if (bus.stop) begin
            state <= IDLE;
          end else if (bitcnt == LAST_BIT) begin
            if (cnt != '0) begin
              state  <= RUN;
              busy_q <= 1'b1;
            end else begin
              state  <= DONE;
              done_q <= 1'b1;
            end
          end else begin
            bitcnt <= bitcnt + BW'(1);
            shreg  <= shifted;
            load_q <= 1'b1;
            busy_q <= 1'b1;
            d_q    <= shifted[W-1];
          end
        end
        RUN: begin
          if (bus.stop) begin
            state <= IDLE;
          end else begin
            if (cnt != '0) begin
              cnt <= cnt - CW'(1);
            end
            // cnt is never zero here, but <= keeps a corrupted count from hanging in RUN.
            if (cnt <= CW'(1)) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              busy_q <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_swap_seq_ctrl.sv
// Bench for swap_seq_ctrl driving a two-FF swap ring; outputs are compared each
// cycle against a phase-count model of a run.
module tb_swap_seq_ctrl;
  localparam int W  = 2;
  localparam int CW = 8;

  logic ck = 1'b0;
  logic cl = 1'b1;
  logic q1, q2;

  int passed = 0;
  int total  = 0;

  int           m_phase = -1;
  logic [W-1:0] m_din   = '0;
  int           m_ncyc  = 0;

  always #10 ck = ~ck;

  swap_seq_ctrl_if #(.W(W), .CW(CW)) bus ();

  swap_seq_ctrl #(.W(W), .CW(CW)) dut (
    .ck  (ck),
    .cl  (cl),
    .bus (bus)
  );

  // Two-flip-flop swap ring under control of the sequencer.
  always @(posedge ck) begin
    if (bus.load) begin
      q1 <= bus.d;
      q2 <= q1;
    end else begin
      q1 <= q2;
      q2 <= q1;
    end
  end

  // Phase = cycles since the accepting edge (1 = first LOAD cycle), -1 = idle.
  task automatic tick();
    @(posedge ck);
    if (cl) begin
      m_phase = -1;
    end else if (m_phase < 0) begin
      if (bus.start) begin
        m_phase = 1;
        m_din   = bus.din;
        m_ncyc  = int'(bus.ncyc);
      end
    end else if (m_phase == W + m_ncyc + 1) begin
      m_phase = -1;
    end else if (bus.stop) begin
      m_phase = -1;
    end else begin
      m_phase++;
    end
    @(negedge ck);
  endtask

  // {load, d, busy, done} expected for the current phase.
  function automatic logic [3:0] exp_out();
    if (m_phase < 0) return 4'b0000;
    if (m_phase <= W) return {1'b1, m_din[W-m_phase], 2'b10};
    if (m_phase <= W + m_ncyc) return 4'b0010;
    return 4'b0001;
  endfunction

  // Loaded ring holds q1=din[0], q2=din[1]; each rotation swaps them.
  function automatic logic [1:0] exp_ring();
    if (m_ncyc % 2 == 0) return {m_din[0], m_din[1]};
    return {m_din[1], m_din[0]};
  endfunction

  function automatic logic [3:0] outs();
    return {bus.load, bus.d, bus.busy, bus.done};
  endfunction

  task automatic test_reset();
    cl = 1'b1;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    bus.din   = '0;
    bus.ncyc  = '0;
    tick();
    tick();
    total++;
    if (outs() !== 4'b0000) $display("[TB] FAIL reset_outputs: got %b expected 0000", outs());
    else passed++;
    cl = 1'b0;
    tick();
    total++;
    if (outs() !== 4'b0000) $display("[TB] FAIL idle_quiet: got %b expected 0000", outs());
    else passed++;
  endtask

  task automatic test_basic();
    logic [3:0] obs, ex;
    int done_at = -1;
    bus.din = 2'b01;
    bus.ncyc = 8'd3;
    bus.start = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      bus.start = 1'b0;
      obs = outs();
      ex = exp_out();
      total++;
      if (obs !== ex) $display("[TB] FAIL basic_outputs cycle %0d: got %b expected %b", c, obs, ex);
      else passed++;
      if (c == 3) begin
        total++;
        if ({q1, q2} !== 2'b10) $display("[TB] FAIL basic_ring_loaded: got %b expected 10", {q1, q2});
        else passed++;
      end
      if (ex[0]) begin
        total++;
        if ({q1, q2} !== exp_ring()) $display("[TB] FAIL basic_ring_done: got %b expected %b", {q1, q2}, exp_ring());
        else passed++;
      end
      if (obs[0] === 1'b1) done_at = c;
    end
    total++;
    if (done_at != 6) $display("[TB] FAIL basic_done_time: got %0d expected 6", done_at);
    else passed++;
  endtask

  task automatic test_no_run();
    logic [3:0] obs, ex;
    int done_at = -1;
    int busy_cnt = 0;
    bus.din = 2'b10;
    bus.ncyc = 8'd0;
    bus.start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      bus.start = 1'b0;
      obs = outs();
      ex = exp_out();
      total++;
      if (obs !== ex) $display("[TB] FAIL norun_outputs cycle %0d: got %b expected %b", c, obs, ex);
      else passed++;
      if (ex[0]) begin
        total++;
        if ({q1, q2} !== 2'b01) $display("[TB] FAIL norun_ring: got %b expected 01", {q1, q2});
        else passed++;
      end
      if (obs[1] === 1'b1) busy_cnt++;
      if (obs[0] === 1'b1) done_at = c;
    end
    total++;
    if (busy_cnt != 2 || done_at != 3)
      $display("[TB] FAIL norun_timing: got busy=%0d done_at=%0d expected busy=2 done_at=3", busy_cnt, done_at);
    else passed++;
  endtask

  task automatic test_start_ignored();
    logic [3:0] obs, ex;
    logic [W-1:0] orig;
    int done_at = -1;
    orig = W'($urandom);
    bus.din = orig;
    bus.ncyc = 8'd4;
    bus.start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      bus.start = 1'b0;
      obs = outs();
      ex = exp_out();
      total++;
      if (obs !== ex) $display("[TB] FAIL ignore_outputs cycle %0d: got %b expected %b", c, obs, ex);
      else passed++;
      if (ex[0]) begin
        total++;
        if ({q1, q2} !== {orig[0], orig[1]}) $display("[TB] FAIL ignore_ring: got %b expected %b", {q1, q2}, {orig[0], orig[1]});
        else passed++;
      end
      if (obs[0] === 1'b1) done_at = c;
      if (c == 4) begin
        bus.start = 1'b1;
        bus.din = ~orig;
        bus.ncyc = 8'd1;
      end
    end
    total++;
    if (done_at != 7) $display("[TB] FAIL ignore_done_time: got %0d expected 7", done_at);
    else passed++;
  endtask

  task automatic test_stop();
    logic [3:0] obs, ex;
    int done_at = -1;
    int done_cnt = 0;
    bus.din = W'($urandom);
    bus.ncyc = 8'd5;
    bus.start = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      tick();
      bus.start = 1'b0;
      bus.stop = 1'b0;
      obs = outs();
      ex = exp_out();
      total++;
      if (obs !== ex) $display("[TB] FAIL stop_outputs cycle %0d: got %b expected %b", c, obs, ex);
      else passed++;
      if (ex[0]) begin
        total++;
        if ({q1, q2} !== exp_ring()) $display("[TB] FAIL stop_ring: got %b expected %b", {q1, q2}, exp_ring());
        else passed++;
      end
      if (obs[0] === 1'b1) begin
        done_at = c;
        done_cnt++;
      end
      if (c == 3) bus.stop = 1'b1;
      if (c == 4) begin
        total++;
        if (obs !== 4'b0000) $display("[TB] FAIL stop_quiet: got %b expected 0000", obs);
        else passed++;
        bus.start = 1'b1;
        bus.din = W'($urandom);
        bus.ncyc = 8'd2;
      end
    end
    total++;
    if (done_cnt != 1 || done_at != 9)
      $display("[TB] FAIL stop_done: got count=%0d at=%0d expected count=1 at=9", done_cnt, done_at);
    else passed++;
  endtask

  task automatic test_reset_mid_load();
    logic [3:0] obs, ex;
    int done_at = -1;
    int done_cnt = 0;
    bus.din = W'($urandom);
    bus.ncyc = 8'd2;
    bus.start = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      tick();
      bus.start = 1'b0;
      cl = 1'b0;
      obs = outs();
      ex = exp_out();
      total++;
      if (obs !== ex) $display("[TB] FAIL clmid_outputs cycle %0d: got %b expected %b", c, obs, ex);
      else passed++;
      if (ex[0]) begin
        total++;
        if ({q1, q2} !== exp_ring()) $display("[TB] FAIL clmid_ring: got %b expected %b", {q1, q2}, exp_ring());
        else passed++;
      end
      if (obs[0] === 1'b1) begin
        done_at = c;
        done_cnt++;
      end
      if (c == 2) cl = 1'b1;
      if (c == 3) begin
        total++;
        if (obs !== 4'b0000) $display("[TB] FAIL clmid_quiet: got %b expected 0000", obs);
        else passed++;
        bus.start = 1'b1;
        bus.din = W'($urandom);
        bus.ncyc = 8'd1;
      end
    end
    total++;
    if (done_cnt != 1 || done_at != 7)
      $display("[TB] FAIL clmid_done: got count=%0d at=%0d expected count=1 at=7", done_cnt, done_at);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [3:0] obs, ex;
    int dones[$];
    bus.din = W'($urandom);
    bus.ncyc = 8'd1;
    bus.start = 1'b1;
    for (int c = 1; c <= 36; c++) begin
      tick();
      if (c == 30) bus.start = 1'b0;
      obs = outs();
      ex = exp_out();
      total++;
      if (obs !== ex) $display("[TB] FAIL b2b_outputs cycle %0d: got %b expected %b", c, obs, ex);
      else passed++;
      if (obs[0] === 1'b1) dones.push_back(c);
    end
    total++;
    if (dones.size() != 6) $display("[TB] FAIL b2b_count: got %0d expected 6", dones.size());
    else passed++;
    for (int i = 1; i < dones.size(); i++) begin
      total++;
      if (dones[i] - dones[i-1] != W + 1 + 2)
        $display("[TB] FAIL b2b_period: got %0d expected %0d", dones[i] - dones[i-1], W + 3);
      else passed++;
    end
  endtask

  task automatic test_random();
    logic [3:0] obs, ex;
    for (int c = 1; c <= 400; c++) begin
      bus.start = ($urandom_range(0, 2) == 0);
      bus.stop  = ($urandom_range(0, 11) == 0);
      cl        = ($urandom_range(0, 59) == 0);
      bus.din   = W'($urandom);
      bus.ncyc  = CW'($urandom_range(0, 6));
      tick();
      obs = outs();
      ex = exp_out();
      total++;
      if (obs !== ex) $display("[TB] FAIL random_outputs cycle %0d: got %b expected %b", c, obs, ex);
      else passed++;
      if (ex[0]) begin
        total++;
        if ({q1, q2} !== exp_ring()) $display("[TB] FAIL random_ring cycle %0d: got %b expected %b", c, {q1, q2}, exp_ring());
        else passed++;
      end
    end
    cl = 1'b0;
    bus.start = 1'b0;
    bus.stop = 1'b0;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    bus.din   = '0;
    bus.ncyc  = '0;
    $display("[TB] swap_seq_ctrl bench, W=%0d", W);
    test_reset();
    test_basic();
    test_no_run();
    test_start_ignored();
    test_stop();
    test_reset_mid_load();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
